// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART baud / oversample generator.
//   - default widths and oversample factor used by uart_baud_os_gen
//   - reset integer divisor
//   - log2 helper used to size the oversample phase index
//   - control decode type shared by the divider
// -----------------------------------------------------------------------------
package uart_pkg;

   // Default integer divisor width.
   localparam int DIV_W_DEF   = 16;
   // Default fractional divisor width (units of 1/2^FRAC_W clock).
   localparam int FRAC_W_DEF  = 4;
   // Default number of oversample ticks per bit.
   localparam int OVS_DEF     = 16;
   // Integer divisor in effect after reset.
   localparam int RST_INT_DEF = 7;

   // Width of an index that counts 0..ovs-1 (never narrower than one bit).
   function automatic int ovs_phase_w(input int ovs);
      int w;
      if (ovs <= 2) begin
         w = 1;
      end else begin
         w = $clog2(ovs);
      end
      return w;
   endfunction

   // Oversample phase width for the default oversample factor.
   localparam int OS_PHASE_W_DEF = ovs_phase_w(OVS_DEF);

   // Per-cycle action of the divider, already resolved by priority.
   typedef enum logic [1:0] {
      CTL_COUNT  = 2'd0,  // normal down-counting
      CTL_LATCH  = 2'd1,  // capture new divisor and restart
      CTL_IDLE   = 2'd2,  // run enable low: hold at period start
      CTL_RESYNC = 2'd3   // re-phase to a bit start
   } div_ctl_e;

endpackage

// File: rtl/frac_tick_div.sv
// -----------------------------------------------------------------------------
// frac_tick_div
// Fractional clock divider producing one pulse per oversample boundary.
// The average boundary spacing is D + frac/2^FRAC_W clocks, with
// D = max(baud_int, 1). The fraction is spread by a first-order accumulator:
// every boundary adds frac to acc and the carry lengthens the next period
// by one clock.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   latch_i      capture baud_int_i / baud_frac_i and restart the period
//   baud_int_i   integer clocks per oversample tick (0 behaves as 1)
//   baud_frac_i  fractional clocks per oversample tick
//   en_i         run enable; low holds the divider at the start of a period
//   resync_i     restart the current period without changing the divisor
//   boundary_o   combinational boundary pulse (cnt reached 0 while counting)
// -----------------------------------------------------------------------------
module frac_tick_div
   import uart_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int FRAC_W  = FRAC_W_DEF,
   parameter int RST_INT = RST_INT_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              latch_i,
   input  logic [DIV_W-1:0]  baud_int_i,
   input  logic [FRAC_W-1:0] baud_frac_i,
   input  logic              en_i,
   input  logic              resync_i,
   output logic              boundary_o
);

   localparam logic [DIV_W-1:0]  ONE_DIV   = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0]  ZERO_DIV  = {DIV_W{1'b0}};
   localparam logic [FRAC_W-1:0] ZERO_FRAC = {FRAC_W{1'b0}};
   // Divisor register value after reset (stored exactly as given).
   localparam logic [DIV_W-1:0]  RST_INT_V = DIV_W'(RST_INT);
   // Effective reset divisor is at least 1, so the reset count is never negative.
   localparam logic [DIV_W-1:0]  RST_D     = (RST_INT < 1) ? ONE_DIV : RST_INT_V;
   localparam logic [DIV_W-1:0]  RST_CNT   = RST_D - ONE_DIV;

   // Effective divisor: a programmed 0 runs at the fastest rate, same as 1.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] v);
      logic [DIV_W-1:0] d;
      if (v == ZERO_DIV) begin
         d = ONE_DIV;
      end else begin
         d = v;
      end
      return d;
   endfunction

   logic [DIV_W-1:0]  int_q, int_d;
   logic [FRAC_W-1:0] frac_q, frac_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;

   logic [DIV_W-1:0]  div_cur_s;
   logic [DIV_W-1:0]  div_new_s;
   logic [FRAC_W:0]   acc_sum_s;
   logic [DIV_W-1:0]  carry_s;
   logic              boundary_s;
   div_ctl_e          ctl_s;

   assign div_cur_s = eff_div(int_q);
   assign div_new_s = eff_div(baud_int_i);
   // One bit wider than acc so the top bit is the carry into the next period.
   assign acc_sum_s = {1'b0, acc_q} + {1'b0, frac_q};
   assign carry_s   = {{(DIV_W-1){1'b0}}, acc_sum_s[FRAC_W]};

   // Resolve this cycle's action: latch beats idle, idle beats resync.
   always_comb begin
      ctl_s = CTL_COUNT;
      if (latch_i) begin
         ctl_s = CTL_LATCH;
      end else if (!en_i) begin
         ctl_s = CTL_IDLE;
      end else if (resync_i) begin
         ctl_s = CTL_RESYNC;
      end else begin
         ctl_s = CTL_COUNT;
      end
   end

   // Next-state of divisor registers, counter and accumulator.
   always_comb begin
      int_d      = int_q;
      frac_d     = frac_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      boundary_s = 1'b0;
      case (ctl_s)
         CTL_LATCH: begin
            // New divisor takes effect on this very reload; no fraction yet.
            int_d  = baud_int_i;
            frac_d = baud_frac_i;
            cnt_d  = div_new_s - ONE_DIV;
            acc_d  = ZERO_FRAC;
         end
         CTL_IDLE, CTL_RESYNC: begin
            cnt_d = div_cur_s - ONE_DIV;
            acc_d = ZERO_FRAC;
         end
         CTL_COUNT: begin
            if (cnt_q == ZERO_DIV) begin
               // Boundary: the carry out of the accumulator stretches the
               // next period by one clock. D >= 1, so D-1+carry fits.
               boundary_s = 1'b1;
               acc_d      = acc_sum_s[FRAC_W-1:0];
               cnt_d      = div_cur_s - ONE_DIV + carry_s;
            end else begin
               cnt_d = cnt_q - ONE_DIV;
            end
         end
         default: begin
            cnt_d = div_cur_s - ONE_DIV;
            acc_d = ZERO_FRAC;
         end
      endcase
   end

   // Divider state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         int_q  <= RST_INT_V;
         frac_q <= ZERO_FRAC;
         cnt_q  <= RST_CNT;
         acc_q  <= ZERO_FRAC;
      end else begin
         int_q  <= int_d;
         frac_q <= frac_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
      end
   end

   assign boundary_o = boundary_s;

endmodule

// File: rtl/uart_baud_os_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_os_gen
// Fractional baud-rate generator producing oversample, mid-bit and bit
// strobes from a runtime divisor (integer + fractional part).
//
// Ports:
//   clk        system clock (single domain)
//   rst        asynchronous active-low reset
//   latch      one-cycle strobe: capture baud_int/baud_frac and restart
//   baud_int   integer clocks per oversample tick (0 behaves as 1)
//   baud_frac  fractional clocks per oversample tick (1/2^FRAC_W units)
//   en         run enable; low holds the generator idle at phase 0
//   resync     one-cycle strobe: re-phase to a bit start (RX start edge)
//   ena_os     oversample tick, one clock wide
//   ena_mid    mid-bit sample tick, coincident with an ena_os
//   ena        bit tick, coincident with an ena_os
//   os_phase   index of the oversample period currently running
//
// All outputs are registered: a tick appears the cycle after the divider's
// counter sits at zero.
// -----------------------------------------------------------------------------
module uart_baud_os_gen
   import uart_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int FRAC_W  = FRAC_W_DEF,
   parameter int OVS     = OVS_DEF,
   parameter int RST_INT = RST_INT_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          latch,
   input  logic [DIV_W-1:0]              baud_int,
   input  logic [FRAC_W-1:0]             baud_frac,
   input  logic                          en,
   input  logic                          resync,
   output logic                          ena_os,
   output logic                          ena_mid,
   output logic                          ena,
   output logic [ovs_phase_w(OVS)-1:0]   os_phase
);

   localparam int              PH_W     = ovs_phase_w(OVS);
   localparam logic [PH_W-1:0] PH_ZERO  = {PH_W{1'b0}};
   localparam logic [PH_W-1:0] PH_ONE   = {{(PH_W-1){1'b0}}, 1'b1};
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OVS - 1);
   localparam logic [PH_W-1:0] PH_MID   = PH_W'(OVS / 2 - 1);

   logic            boundary_s;
   logic            restart_s;
   logic [PH_W-1:0] os_cnt_q, os_cnt_d;
   logic            ena_os_q, ena_os_d;
   logic            ena_mid_q, ena_mid_d;
   logic            ena_q, ena_d;

   frac_tick_div #(
      .DIV_W   (DIV_W),
      .FRAC_W  (FRAC_W),
      .RST_INT (RST_INT)
   ) u_div (
      .clk_i       (clk),
      .rst_ni      (rst),
      .latch_i     (latch),
      .baud_int_i  (baud_int),
      .baud_frac_i (baud_frac),
      .en_i        (en),
      .resync_i    (resync),
      .boundary_o  (boundary_s)
   );

   // Any of these sends the bit back to oversample index 0.
   assign restart_s = latch | ~en | resync;

   // Next oversample index and tick decode.
   always_comb begin
      os_cnt_d  = os_cnt_q;
      ena_os_d  = 1'b0;
      ena_mid_d = 1'b0;
      ena_d     = 1'b0;
      if (restart_s) begin
         // The divider already suppresses its boundary here.
         os_cnt_d = PH_ZERO;
      end else if (boundary_s) begin
         // Decode on the index of the period that is ending.
         ena_os_d  = 1'b1;
         ena_mid_d = (os_cnt_q == PH_MID);
         ena_d     = (os_cnt_q == PH_LAST);
         if (os_cnt_q == PH_LAST) begin
            os_cnt_d = PH_ZERO;
         end else begin
            os_cnt_d = os_cnt_q + PH_ONE;
         end
      end else begin
         os_cnt_d = os_cnt_q;
      end
   end

   // Oversample index and output strobe registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         os_cnt_q  <= PH_ZERO;
         ena_os_q  <= 1'b0;
         ena_mid_q <= 1'b0;
         ena_q     <= 1'b0;
      end else begin
         os_cnt_q  <= os_cnt_d;
         ena_os_q  <= ena_os_d;
         ena_mid_q <= ena_mid_d;
         ena_q     <= ena_d;
      end
   end

   assign ena_os   = ena_os_q;
   assign ena_mid  = ena_mid_q;
   assign ena      = ena_q;
   assign os_phase = os_cnt_q;

endmodule

// File: doc/uart_baud_os_gen.md
# uart_baud_os_gen

Parametrised fractional baud-rate generator for the UART path of sig_acq. It produces three strobes from a runtime divisor with an integer part and a fractional part:
- an oversample tick for the RX sampler;
- a mid-bit sample tick;
- a bit tick for TX/RX bit timing.

It replaces the single-tick integer generator, adding fractional division, a parametrised oversample factor, RX start-edge re-phasing and a run enable.

## Interface
- DIV_W, 16, width of integer divisor
- FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W clock)
- OVS, 16, oversample ticks per bit; power of two, 4..64
- RST_INT, 7, integer divisor in effect after reset (fraction 0)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- latch  in  1  one-cycle strobe: capture baud_int/baud_frac and restart
- baud_int  in  DIV_W  integer clocks per oversample tick; 0 treated as 1
- baud_frac  in  FRAC_W  fractional clocks per oversample tick
- en  in  1  run enable; low holds generator idle
- resync  in  1  one-cycle strobe: re-phase to bit start (RX start edge)
- ena_os  out  1  oversample tick, one clk wide
- ena_mid  out  1  mid-bit sample tick, one clk wide
- ena  out  1  bit tick, one clk wide
- os_phase  out  log2(OVS)  current oversample index within the bit

## Operation
- D = max(baud_int_r, 1). cnt is a DIV_W-bit down-counter; reaching 0 marks an oversample boundary.
- The fractional accumulator acc is FRAC_W bits. At each boundary: {carry, acc} <= acc + frac_r, and cnt reloads D-1+carry.
- The average oversample period is therefore D + frac_r/2^FRAC_W clocks.
- If D=1 and frac_r=0, ena_os is asserted every cycle.
- os_cnt counts boundaries 0..OVS-1 and wraps to 0. os_phase = os_cnt.
- ena is set on a boundary where os_cnt==OVS-1.
- ena_mid is set on a boundary where os_cnt==OVS/2-1.
- Priority per cycle: rst > latch > !en > resync > count.
- latch:
  - baud_int_r/frac_r <= inputs;
  - cnt <= D_new-1, where D_new uses the incoming value;
  - acc <= 0 and os_cnt <= 0;
  - no ticks are produced in that cycle.
- !en: cnt <= D-1, acc <= 0, os_cnt <= 0, all ticks 0. Divisor registers are kept.
- resync: cnt <= D-1, acc <= 0, os_cnt <= 0, no tick that cycle. The first ena_mid then follows after OVS/2 oversample periods, and ena after OVS.
- A latch, !en or resync coinciding with cnt==0 suppresses that cycle's tick.
- Reset values:
  - cnt = RST_INT-1; baud_int_r = RST_INT; frac_r = 0;
  - acc = 0; os_cnt = 0;
  - ena_os = ena_mid = ena = 0.
- All widths are unsigned. D-1+carry never overflows DIV_W because carry is only added when D>=1.

## Timing
- All outputs are registered. A tick is high for the single cycle after the cycle in which cnt==0.
- Counting starts on the first clk edge after rst deasserts. Provided en=1, the first ena_os appears on cycle RST_INT (counting from cycle 0 = first edge with rst high).
- After latch in cycle t, with en=1, the first ena_os is at t+D+1 (fraction not applied to the first period).
- ena and ena_mid are exactly coincident with an ena_os pulse, never standalone.
- os_phase updates on the same edge as the registered tick. It reads the index of the period now running.
- Reset asserted mid-operation clears everything asynchronously. A tick in flight is dropped.

## Structure
- Shared package uart_pkg holds:
  - default widths DIV_W_DEF=16, FRAC_W_DEF=4, OVS_DEF=16;
  - RST_INT_DEF=7;
  - the log2 helper constant for os_phase width.
- Sub-module frac_tick_div holds the divisor registers, cnt and acc. Its inputs are latch, en and resync; its output is a single boundary pulse.
- The top level holds os_cnt and the three output registers.

## Test plan
- Reset release, en=1, no latch -> ena_os pulses with a period of 7 clks; the first pulse is at cycle 7; ena pulses every 112 clks (OVS=16).
- latch baud_int=4, baud_frac=0 -> ena_os every 4 clks; ena_mid at boundary 8; ena every 64 clks; os_phase 0..15 wrapping.
- latch baud_int=4, baud_frac=8 (FRAC_W=4) -> ena_os periods 4,4,5,4,5,... After settling, the average over 32 ticks is 144 clks.
- baud_int=0 and baud_int=1, frac=0 -> ena_os high every cycle; ena every 16 cycles.
- resync mid-bit at os_phase=11 -> no tick that cycle; ena_mid exactly 8·D+1 clks later; ena 16·D+1 clks later.
- latch coincident with cnt==0, then en low for 10 cycles -> no tick in the latch cycle; all ticks 0 while en=0; restart from phase 0 with the new divisor.
